// File: rtl/multi_edge_detect_pkg.sv
// Shared constants for multi_edge_detect: edge-select codes, filter state
// encoding and the stable-counter width helper.
package multi_edge_detect_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam logic FILT_STABLE  = 1'b0;
  localparam logic FILT_PENDING = 1'b1;

  // max(1, clog2(min_width)): holds every count value up to min_width-1.
  function automatic int cnt_width(input int min_width);
    return (min_width <= 2) ? 1 : $clog2(min_width);
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser chain, minimum-width filter FSM and registered edge pulses.
// Optional high-pulse width measurement is built when PULSE_WIDTH_EN is defined.
module edge_filter_ch
  import multi_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 1,
  parameter int INIT_LEVEL  = 0
`ifdef PULSE_WIDTH_EN
  ,
  parameter int PW_W        = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trig,
  input  logic [1:0]      edge_sel,
  output logic            level,
  output logic            pos_edge,
  output logic            neg_edge,
  output logic            evt,
  output logic            glitch
`ifdef PULSE_WIDTH_EN
  ,
  output logic [PW_W-1:0] pw,
  output logic            pw_valid
`endif
);

  localparam int             CW       = cnt_width(MIN_WIDTH);
  localparam logic           INIT     = 1'(INIT_LEVEL);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MIN_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pos_q, neg_q, evt_q, glitch_q;
  logic                   pos_d, neg_d, glitch_d, accept;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    glitch_d = 1'b0;
    accept   = 1'b0;
    case (state_q)
      FILT_STABLE: begin
        if (s != level_q) begin
          if (MIN_WIDTH == 1) begin
            accept = 1'b1;
          end else begin
            // The first mismatching sample already counts toward the width.
            state_d = FILT_PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      default: begin
        if (s == level_q) begin
          state_d  = FILT_STABLE;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    if (accept) begin
      level_d = s;
      state_d = FILT_STABLE;
      cnt_d   = '0;
    end
    pos_d = accept & s;
    neg_d = accept & ~s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{INIT}};
      state_q  <= FILT_STABLE;
      cnt_q    <= '0;
      level_q  <= INIT;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      evt_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], trig};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      evt_q    <= (pos_d && (edge_sel == EDGE_RISE || edge_sel == EDGE_BOTH)) ||
                  (neg_d && (edge_sel == EDGE_FALL || edge_sel == EDGE_BOTH));
      glitch_q <= glitch_d;
    end
  end

  assign level    = level_q;
  assign pos_edge = pos_q;
  assign neg_edge = neg_q;
  assign evt      = evt_q;
  assign glitch   = glitch_q;

`ifdef PULSE_WIDTH_EN
  localparam logic [PW_W-1:0] PW_MAX = '1;

  logic [PW_W-1:0] wcnt_q, pw_q;
  logic            pw_valid_q;

  // Reported width is the number of cycles the filtered level was high.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q     <= '0;
      pw_q       <= '0;
      pw_valid_q <= 1'b0;
    end else begin
      pw_valid_q <= neg_d;
      if (pos_d) begin
        wcnt_q <= '0;
      end else if (level_q && wcnt_q != PW_MAX) begin
        wcnt_q <= wcnt_q + PW_W'(1);
      end
      if (neg_d) begin
        pw_q <= (wcnt_q == PW_MAX) ? PW_MAX : wcnt_q + PW_W'(1);
      end
    end
  end

  assign pw       = pw_q;
  assign pw_valid = pw_valid_q;
`endif

endmodule

// File: rtl/multi_edge_detect.sv
// N_CH-channel synchronising, glitch-filtering edge detector with runtime edge select.
// Define PULSE_WIDTH_EN to add per-channel high-pulse width reporting (pw, pw_valid).
module multi_edge_detect
  import multi_edge_detect_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 1,
  parameter int INIT_LEVEL  = 0
`ifdef PULSE_WIDTH_EN
  ,
  parameter int PW_W        = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        trig,
  input  logic [2*N_CH-1:0]      edge_sel,
  output logic [N_CH-1:0]        level,
  output logic [N_CH-1:0]        pos_edge,
  output logic [N_CH-1:0]        neg_edge,
  output logic [N_CH-1:0]        evt,
  output logic [N_CH-1:0]        glitch
`ifdef PULSE_WIDTH_EN
  ,
  output logic [N_CH*PW_W-1:0]   pw,
  output logic [N_CH-1:0]        pw_valid
`endif
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_WIDTH   (MIN_WIDTH),
      .INIT_LEVEL  (INIT_LEVEL)
`ifdef PULSE_WIDTH_EN
      ,
      .PW_W        (PW_W)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .trig     (trig[gi]),
      .edge_sel (edge_sel[2*gi +: 2]),
      .level    (level[gi]),
      .pos_edge (pos_edge[gi]),
      .neg_edge (neg_edge[gi]),
      .evt      (evt[gi]),
      .glitch   (glitch[gi])
`ifdef PULSE_WIDTH_EN
      ,
      .pw       (pw[PW_W*gi +: PW_W]),
      .pw_valid (pw_valid[gi])
`endif
    );
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: three instances (default, MIN_WIDTH=4, INIT_LEVEL=1)
// checked by directed scenarios and a run-length reference model under random stimulus.
module tb_multi_edge_detect;
  import multi_edge_detect_pkg::*;

  localparam int NI = 3;
  localparam int       MW_OF    [NI] = '{1, 4, 1};
  localparam logic [3:0] IL_OF  [NI] = '{4'h0, 4'h0, 4'hF};
  localparam int       PWMAX_OF [NI] = '{65535, 65535, 15};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0][3:0] trig_v, level_v, pos_v, neg_v, evt_v, glitch_v;
  logic [NI-1:0][7:0] sel_v;
`ifdef PULSE_WIDTH_EN
  logic [63:0] a_pw, b_pw;
  logic [15:0] c_pw;
  logic [NI-1:0][3:0] pwv_v;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multi_edge_detect #(.N_CH(4), .SYNC_STAGES(2), .MIN_WIDTH(1), .INIT_LEVEL(0)) dut_a (
    .clk(clk), .rst(rst), .trig(trig_v[0]), .edge_sel(sel_v[0]), .level(level_v[0]),
    .pos_edge(pos_v[0]), .neg_edge(neg_v[0]), .evt(evt_v[0]), .glitch(glitch_v[0])
`ifdef PULSE_WIDTH_EN
    , .pw(a_pw), .pw_valid(pwv_v[0])
`endif
  );

  multi_edge_detect #(.N_CH(4), .SYNC_STAGES(2), .MIN_WIDTH(4), .INIT_LEVEL(0)) dut_b (
    .clk(clk), .rst(rst), .trig(trig_v[1]), .edge_sel(sel_v[1]), .level(level_v[1]),
    .pos_edge(pos_v[1]), .neg_edge(neg_v[1]), .evt(evt_v[1]), .glitch(glitch_v[1])
`ifdef PULSE_WIDTH_EN
    , .pw(b_pw), .pw_valid(pwv_v[1])
`endif
  );

  multi_edge_detect #(.N_CH(4), .SYNC_STAGES(2), .MIN_WIDTH(1), .INIT_LEVEL(1)
`ifdef PULSE_WIDTH_EN
    , .PW_W(4)
`endif
  ) dut_c (
    .clk(clk), .rst(rst), .trig(trig_v[2]), .edge_sel(sel_v[2]), .level(level_v[2]),
    .pos_edge(pos_v[2]), .neg_edge(neg_v[2]), .evt(evt_v[2]), .glitch(glitch_v[2])
`ifdef PULSE_WIDTH_EN
    , .pw(c_pw), .pw_valid(pwv_v[2])
`endif
  );

  // Reference model: a level flips once the synchronised input has disagreed with it
  // for MIN_WIDTH consecutive samples; a broken run of disagreement is a glitch.
  logic [NI-1:0][3:0] m_old, m_new;
  logic [NI-1:0][3:0] e_level, e_pos, e_neg, e_evt, e_glitch, e_pwv;
  int m_run [NI][4];
  int m_start [NI][4];
  int e_pw [NI][4];
  int cyc = 0;

  always @(posedge clk) begin
    logic [3:0] smp;
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      e_pos[i] = '0; e_neg[i] = '0; e_evt[i] = '0; e_glitch[i] = '0; e_pwv[i] = '0;
      if (rst) begin
        m_old[i] = IL_OF[i]; m_new[i] = IL_OF[i]; e_level[i] = IL_OF[i];
        for (int c = 0; c < 4; c++) begin
          m_run[i][c] = 0; m_start[i][c] = cyc; e_pw[i][c] = 0;
        end
      end else begin
        smp = m_old[i];
        m_old[i] = m_new[i];
        m_new[i] = trig_v[i];
        for (int c = 0; c < 4; c++) begin
          if (smp[c] != e_level[i][c]) begin
            m_run[i][c] = m_run[i][c] + 1;
            if (m_run[i][c] == MW_OF[i]) begin
              m_run[i][c] = 0;
              e_level[i][c] = smp[c];
              if (smp[c]) begin
                e_pos[i][c] = 1'b1;
                m_start[i][c] = cyc;
              end else begin
                e_neg[i][c] = 1'b1;
                e_pwv[i][c] = 1'b1;
                e_pw[i][c] = (cyc - m_start[i][c] > PWMAX_OF[i]) ? PWMAX_OF[i] : cyc - m_start[i][c];
              end
            end
          end else begin
            if (m_run[i][c] > 0) e_glitch[i][c] = 1'b1;
            m_run[i][c] = 0;
          end
          e_evt[i][c] = (e_pos[i][c] & sel_v[i][2*c]) | (e_neg[i][c] & sel_v[i][2*c+1]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      total++;
      if ({level_v[i], pos_v[i], neg_v[i], evt_v[i], glitch_v[i]} !== {IL_OF[i], 16'h0000}) begin
        bad++;
        $display("FAIL reset inst=%0d got=%h required=%h", i,
                 {level_v[i], pos_v[i], neg_v[i], evt_v[i], glitch_v[i]}, {IL_OF[i], 16'h0000});
      end
    end
`ifdef PULSE_WIDTH_EN
    total++;
    if ({a_pw, b_pw, c_pw, pwv_v} !== '0) begin
      bad++;
      $display("FAIL reset_pw got=%h required=0", {a_pw, b_pw, c_pw, pwv_v});
    end
`endif
    rst = 1'b0;
    $display("reset: outputs checked on all instances");
  endtask

  task automatic test_latency();
    logic [3:0] exp_pos;
    repeat (4) tick();
    trig_v[0][0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_pos = (k == 3) ? 4'h1 : 4'h0;
      total++;
      if (pos_v[0] !== exp_pos || neg_v[0] !== 4'h0) begin
        bad++;
        $display("FAIL latency k=%0d pos=%h neg=%h required pos=%h neg=0", k, pos_v[0], neg_v[0], exp_pos);
      end
    end
    total++;
    if (level_v[0] !== 4'h1) begin
      bad++;
      $display("FAIL latency_level got=%h required=1", level_v[0]);
    end
    trig_v[0][0] = 1'b0;
    repeat (6) tick();
    $display("latency: rising edge on ch0 checked");
  endtask

  task automatic test_glitch();
    int n_gl, n_pos, n_neg, n_hi;
    n_gl = 0; n_pos = 0; n_hi = 0;
    trig_v[1][1] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 2) trig_v[1][1] = 1'b0;
      n_gl += int'(glitch_v[1][1]);
      n_pos += int'(pos_v[1][1]);
      n_hi += int'(level_v[1][1]);
    end
    total++;
    if (n_gl != 1 || n_pos != 0 || n_hi != 0) begin
      bad++;
      $display("FAIL glitch_short glitches=%0d pos=%0d level_hi=%0d required 1/0/0", n_gl, n_pos, n_hi);
    end
    n_gl = 0; n_pos = 0; n_neg = 0;
    trig_v[1][1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 3) trig_v[1][1] = 1'b0;
      n_gl += int'(glitch_v[1][1]);
      n_pos += int'(pos_v[1][1]);
      n_neg += int'(neg_v[1][1]);
    end
    total++;
    if (n_gl != 0 || n_pos != 1 || n_neg != 1) begin
      bad++;
      $display("FAIL glitch_full glitches=%0d pos=%0d neg=%0d required 0/1/1", n_gl, n_pos, n_neg);
    end
    $display("glitch: short and minimum-width pulses on MIN_WIDTH=4 ch1 checked");
  endtask

  task automatic test_edge_sel();
    logic [1:0] sels [4] = '{EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE};
    int n_evt, n_pos, n_neg, exp_evt;
    for (int j = 0; j < 4; j++) begin
      sel_v[0][5:4] = sels[j];
      exp_evt = int'(sels[j] == EDGE_RISE || sels[j] == EDGE_BOTH) +
                int'(sels[j] == EDGE_FALL || sels[j] == EDGE_BOTH);
      n_evt = 0; n_pos = 0; n_neg = 0;
      trig_v[0][2] = 1'b1;
      for (int k = 0; k < 14; k++) begin
        tick();
        if (k == 4) trig_v[0][2] = 1'b0;
        n_evt += int'(evt_v[0][2]);
        n_pos += int'(pos_v[0][2]);
        n_neg += int'(neg_v[0][2]);
      end
      total++;
      if (n_evt != exp_evt) begin
        bad++;
        $display("FAIL edge_sel sel=%b events=%0d required=%0d", sels[j], n_evt, exp_evt);
      end
      total++;
      if (n_pos != 1 || n_neg != 1) begin
        bad++;
        $display("FAIL edge_sel_pulses sel=%b pos=%0d neg=%0d required 1/1", sels[j], n_pos, n_neg);
      end
    end
    $display("edge_sel: four select codes on ch2 checked");
  endtask

  task automatic test_simultaneous();
    int n_full, n_part;
    n_full = 0; n_part = 0;
    trig_v[0] = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (pos_v[0] == 4'hF) n_full++;
      else if (pos_v[0] != 4'h0) n_part++;
    end
    total++;
    if (n_full != 1 || n_part != 0) begin
      bad++;
      $display("FAIL simultaneous_rise full=%0d partial=%0d required 1/0", n_full, n_part);
    end
    n_full = 0; n_part = 0;
    trig_v[0] = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (neg_v[0] == 4'hF) n_full++;
      else if (neg_v[0] != 4'h0) n_part++;
    end
    total++;
    if (n_full != 1 || n_part != 0) begin
      bad++;
      $display("FAIL simultaneous_fall full=%0d partial=%0d required 1/0", n_full, n_part);
    end
    $display("simultaneous: all-channel rise and fall checked");
  endtask

  task automatic test_reset_pending();
    int n_ev;
    trig_v[1] = 4'hF;
    repeat (4) tick();
    rst = 1'b1;
    trig_v[1] = 4'h0;
    tick();
    total++;
    if ({level_v[1], pos_v[1], neg_v[1], evt_v[1], glitch_v[1]} !== 20'h0) begin
      bad++;
      $display("FAIL reset_pending got=%h required=0", {level_v[1], pos_v[1], neg_v[1], evt_v[1], glitch_v[1]});
    end
    rst = 1'b0;
    n_ev = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if ((glitch_v[1] | pos_v[1] | neg_v[1]) != 4'h0) n_ev++;
    end
    total++;
    if (n_ev != 0) begin
      bad++;
      $display("FAIL reset_pending_after pulses=%0d required=0", n_ev);
    end
    $display("reset_pending: reset during pending transition checked");
  endtask

  task automatic test_init_level();
    logic [3:0] exp_neg;
    trig_v[2] = 4'h0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_neg = (k == 3) ? 4'hF : 4'h0;
      total++;
      if (neg_v[2] !== exp_neg || pos_v[2] !== 4'h0) begin
        bad++;
        $display("FAIL init_level k=%0d neg=%h pos=%h required neg=%h pos=0", k, neg_v[2], pos_v[2], exp_neg);
      end
`ifdef PULSE_WIDTH_EN
      total++;
      if (pwv_v[2] !== exp_neg || (k == 3 && c_pw !== 16'h3333)) begin
        bad++;
        $display("FAIL init_level_pw k=%0d pw=%h valid=%h required valid=%h", k, c_pw, pwv_v[2], exp_neg);
      end
`endif
    end
    $display("init_level: INIT_LEVEL=1 with low input at release checked");
  endtask

`ifdef PULSE_WIDTH_EN
  task automatic test_pulse_width();
    int seen;
    seen = 0;
    trig_v[0][3] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 9) trig_v[0][3] = 1'b0;
      if (neg_v[0][3]) begin
        seen++;
        total++;
        if (a_pw[63:48] !== 16'd10 || pwv_v[0][3] !== 1'b1) begin
          bad++;
          $display("FAIL pw_10 pw=%0d valid=%b required pw=10 valid=1", a_pw[63:48], pwv_v[0][3]);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL pw_10_count falls=%0d required=1", seen);
    end
    seen = 0;
    trig_v[2][0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (k == 39) trig_v[2][0] = 1'b0;
      if (neg_v[2][0]) begin
        seen++;
        total++;
        if (c_pw[3:0] !== 4'd15 || pwv_v[2][0] !== 1'b1) begin
          bad++;
          $display("FAIL pw_sat pw=%0d valid=%b required pw=15 valid=1", c_pw[3:0], pwv_v[2][0]);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL pw_sat_count falls=%0d required=1", seen);
    end
    $display("pulse_width: 10-cycle and saturating pulses checked");
  endtask
`endif

  task automatic test_random(input int n, input int odds);
    int bad0;
    bad0 = bad;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < 4; c++)
          if ($urandom_range(odds) == 0) trig_v[i][c] = ~trig_v[i][c];
      if ($urandom_range(7) == 0) sel_v = 24'($urandom);
      tick();
      for (int i = 0; i < NI; i++) begin
        total++;
        if ({level_v[i], pos_v[i], neg_v[i], evt_v[i], glitch_v[i]} !==
            {e_level[i], e_pos[i], e_neg[i], e_evt[i], e_glitch[i]}) begin
          bad++;
          $display("FAIL random inst=%0d k=%0d got lvl/pos/neg/evt/glt=%h required=%h", i, k,
                   {level_v[i], pos_v[i], neg_v[i], evt_v[i], glitch_v[i]},
                   {e_level[i], e_pos[i], e_neg[i], e_evt[i], e_glitch[i]});
        end
      end
`ifdef PULSE_WIDTH_EN
      begin
        logic [63:0] ea, eb;
        logic [15:0] ec;
        for (int c = 0; c < 4; c++) begin
          ea[16*c +: 16] = 16'(e_pw[0][c]);
          eb[16*c +: 16] = 16'(e_pw[1][c]);
          ec[4*c +: 4]   = 4'(e_pw[2][c]);
        end
        total++;
        if ({a_pw, b_pw, c_pw, pwv_v} !== {ea, eb, ec, e_pwv}) begin
          bad++;
          $display("FAIL random_pw k=%0d got=%h required=%h", k, {a_pw, b_pw, c_pw, pwv_v}, {ea, eb, ec, e_pwv});
        end
      end
`endif
    end
    $display("random: %0d cycles toggle odds 1/%0d, %0d new bad", n, odds + 1, bad - bad0);
  endtask

  initial begin
    trig_v = '0;
    trig_v[2] = 4'hF;
    sel_v = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_edge_sel();
    test_simultaneous();
    test_reset_pending();
    test_init_level();
`ifdef PULSE_WIDTH_EN
    test_pulse_width();
`endif
    test_random(600, 3);
    test_random(600, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
Name: multi_edge_detect

Overview:
- Parametrised successor to the single-channel trigger edge detector, running in the 460 MHz counting clock domain.
- Adds per-channel N-flop synchroniser, minimum-width glitch filter and runtime edge-type select for N_CH trigger/PMT discriminator inputs.
- Emits registered one-cycle pos/neg/selected-event pulses plus filtered level.
- Feeds the counter and gate logic downstream.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- MIN_WIDTH, 1, consecutive stable cycles needed to accept a level change (>=1; 1 = no filtering).
- INIT_LEVEL, 0, reset value of synchroniser flops and filtered level (0 or 1, all channels).
- PW_W, 16, pulse-width counter width (used only with PULSE_WIDTH_EN).

Ports:
- clk  in  1  counting clock
- rst  in  1  synchronous active-high reset
- trig  in  N_CH  asynchronous raw inputs
- edge_sel  in  2*N_CH  per-channel select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
- level  out  N_CH  filtered level
- pos_edge  out  N_CH  one-cycle pulse on accepted rising transition
- neg_edge  out  N_CH  one-cycle pulse on accepted falling transition
- event  out  N_CH  pos/neg pulse gated by edge_sel
- glitch  out  N_CH  one-cycle pulse when a pending transition is abandoned
- pw  out  N_CH*PW_W  last high-pulse width, channel i at [PW_W*i +: PW_W] (PULSE_WIDTH_EN only)
- pw_valid  out  N_CH  one-cycle pulse when pw[i] updates (PULSE_WIDTH_EN only)

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high: rst sampled on rising clk.
- Reset values:
  - sync chain = INIT_LEVEL, level = INIT_LEVEL.
  - stable counter = 0.
  - pos_edge, neg_edge, event, glitch, pw_valid = 0; pw = 0.
- Reset mid-operation discards any pending transition; no glitch pulse is generated.
- Synchroniser: s = output of the SYNC_STAGES-deep flop chain.
- Per-channel filter states:
  - STABLE: s == level; cnt = 0.
  - PENDING: s != level; cnt counts.
- Transitions:
  - STABLE -> PENDING when s != level. If MIN_WIDTH == 1, the level is accepted on that same edge and the channel stays STABLE.
  - PENDING with s != level and cnt == MIN_WIDTH-1: level <= s, cnt <= 0, registered edge pulse, -> STABLE.
  - PENDING with s != level and cnt below threshold: cnt <= cnt+1.
  - PENDING with s == level: cnt <= 0, glitch <= 1 for one cycle, -> STABLE.
- Latency: pos_edge/neg_edge is high in the cycle following the (SYNC_STAGES+MIN_WIDTH)-th rising clk edge that samples the new trig level. Default: 3 cycles.
- Width rules:
  - A trig pulse shorter than MIN_WIDTH cycles (after sync) never produces an edge.
  - Minimum re-trigger spacing = MIN_WIDTH cycles per transition.
- Output relations:
  - pos_edge and neg_edge are mutually exclusive per channel, each exactly 1 cycle wide.
  - event[i] = (pos_edge[i] & edge_sel[2i]) | (neg_edge[i] & edge_sel[2i+1]). edge_sel is sampled on the same edge that registers the pulse, so a changed edge_sel takes effect on the next accepted edge.
- If trig differs from INIT_LEVEL at reset release, one edge is reported after the normal latency.
- Channels are fully independent; simultaneous edges on all channels are all reported in the same cycle.
- cnt width = max(1, clog2(MIN_WIDTH)).

Optional Feature:
- Macro PULSE_WIDTH_EN.
- Defined:
  - Per-channel PW_W-bit counter clears on accepted rising edge and increments each cycle while level == 1, saturating at all-ones.
  - On accepted falling edge: pw[i] <= count+1 (saturating), pw_valid[i] pulses one cycle, same cycle as neg_edge.
  - Falling edge with no preceding rising edge since reset (INIT_LEVEL=1) reports the cycles since reset.
- Undefined: pw and pw_valid ports are absent; no width counter logic.

Decomposition:
- Package multi_edge_detect_pkg: localparams EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11; filter state encoding.
- Sub-module edge_filter_ch: one channel (sync chain, filter FSM, optional width counter).
- Top instantiates N_CH copies via generate.

Test Plan:
- Default params, rst 2 cycles, trig[0] 0->1 held -> pos_edge[0] high exactly 1 cycle, 3 cycles after first sampling edge; level[0]=1; no other channel toggles.
- MIN_WIDTH=4, trig[1] high for 3 cycles then low -> no pos_edge, glitch[1] pulses once, level[1] stays 0. High for 4 cycles -> pos_edge then neg_edge, each 1 cycle.
- edge_sel=01/10/11/00 on ch2 with one full pulse -> event[2] fires on rise only / fall only / both / never; pos_edge/neg_edge unaffected.
- All 4 channels rise on the same cycle -> pos_edge=4'b1111 for one cycle. Assert rst mid-PENDING (MIN_WIDTH=4) -> all outputs 0 next cycle, no glitch.
- INIT_LEVEL=1 with trig held 0 through reset release -> single neg_edge at latency, none thereafter.
- PULSE_WIDTH_EN, MIN_WIDTH=1: 10-cycle high pulse -> pw=10 with pw_valid coincident with neg_edge. PW_W=4 with 40-cycle pulse -> pw=15 (saturated).
